// File: rtl/n2_pkg.sv
// Shared definitions for the n2 sigmoid cluster and its coefficient loader.
package n2_pkg;

  // Default coefficient width, segment count and segment address width.
  localparam int N_DEF      = 16;
  localparam int SEGS_DEF   = 16;
  localparam int ADDR_W_DEF = 4;

  // Coefficient loader sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_A,
    WAIT_B,
    WRITE,
    DONE
  } load_state_e;

endpackage

// File: rtl/n2_coef_loader_if.sv
// Coefficient stream and RAM-write bus between the config fetch path,
// the loader and the n2_cluster coefficient RAM.
interface n2_coef_loader_if #(
  parameter int N      = n2_pkg::N_DEF,
  parameter int ADDR_W = n2_pkg::ADDR_W_DEF
) ();

  logic              i_start;
  logic [N-1:0]      i_data;
  logic              i_valid;
  logic              o_ready;
  logic [2*N-1:0]    o_coef;
  logic [ADDR_W-1:0] o_coef_addr;
  logic              o_load_coef;
  logic              o_busy;
  logic              o_done;

  // Controller / stream source side.
  modport master (
    output i_start, i_data, i_valid,
    input  o_ready, o_coef, o_coef_addr, o_load_coef, o_busy, o_done
  );

  // Loader side.
  modport slave (
    input  i_start, i_data, i_valid,
    output o_ready, o_coef, o_coef_addr, o_load_coef, o_busy, o_done
  );

endinterface

// File: rtl/n2_coef_loader.sv
// Packs a streamed (a0, b0, a1, b1, ...) coefficient sequence into {ai, bi}
// words and writes one word per segment into the n2_cluster coefficient RAM.
module n2_coef_loader
  import n2_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int SEGS   = SEGS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  n2_coef_loader_if.slave     bus
);

  load_state_e       state;
  load_state_e       state_nxt;
  logic [N-1:0]      a_q;
  logic [ADDR_W-1:0] seg;
  logic [2*N-1:0]    coef_q;
  logic [ADDR_W-1:0] coef_addr_q;
  logic              ready;
  logic              load_coef;
  logic              busy;
  logic              done;
  logic              last_seg;

  // The terminal compare keeps seg from ever wrapping within one load.
  assign last_seg = (seg == ADDR_W'(SEGS - 1));

  // State register; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and output decode; ready depends on state only, never on i_valid.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_nxt = state;
    ready     = 1'b0;
    load_coef = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.i_start) state_nxt = WAIT_A;
      end
      WAIT_A: begin
        ready = 1'b1;
        if (bus.i_valid) state_nxt = WAIT_B;
      end
      WAIT_B: begin
        ready = 1'b1;
        if (bus.i_valid) state_nxt = WRITE;
      end
      WRITE: begin
        load_coef = 1'b1;
        state_nxt = last_seg ? DONE : WAIT_A;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Coefficient capture, packed write word and segment counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      seg         <= '0;
      coef_q      <= '0;
      coef_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          seg <= '0;
        end
        WAIT_A: begin
          if (bus.i_valid) a_q <= bus.i_data;
        end
        WAIT_B: begin
          // The b handshake completes the pair, so the write word is built
          // here and is already stable for the whole WRITE cycle.
          if (bus.i_valid) begin
            coef_q      <= {a_q, bus.i_data};
            coef_addr_q <= seg;
          end
        end
        WRITE: begin
          if (!last_seg) seg <= seg + ADDR_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_load_coef = load_coef;
  assign bus.o_busy      = busy;
  assign bus.o_done      = done;
  assign bus.o_coef      = coef_q;
  assign bus.o_coef_addr = coef_addr_q;

endmodule

// File: tb/tb_n2_coef_loader.sv
// Self-checking bench for n2_coef_loader: the stream source pushes the
// expected {addr, coef, cycle} of every completed pair into a scoreboard,
// and a negedge monitor pops and compares each RAM write.
module tb_n2_coef_loader;
  import n2_pkg::*;

  localparam int N    = N_DEF;
  localparam int SEGS = SEGS_DEF;
  localparam int AW   = ADDR_W_DEF;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [2*N-1:0] coef;
    int             rel;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  n2_coef_loader_if #(.N(N), .ADDR_W(AW)) bus ();

  n2_coef_loader #(.N(N), .SEGS(SEGS), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;

  wr_exp_t        sb[$];
  logic [N-1:0]   a_vals[SEGS];
  logic [N-1:0]   b_vals[SEGS];
  logic [2*N-1:0] ram[SEGS];

  bit mon_en   = 1'b0;
  bit chk_busy = 1'b0;
  int writes_seen;
  int done_cnt;
  int done_rel;
  int last_wr_rel;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every o_load_coef must match the head of the scoreboard.
  always @(negedge clk) begin
    int      rel;
    wr_exp_t e;
    logic    exp_busy;
    if (mon_en) begin
      rel = cyc - start_cyc;
      if (bus.o_load_coef === 1'b1) begin
        writes_seen++;
        last_wr_rel = rel;
        ram[bus.o_coef_addr] = bus.o_coef;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL write_unexpected: got addr=%0d coef=%h at cycle %0d, expected no write",
                   bus.o_coef_addr, bus.o_coef, rel);
        end else begin
          e = sb.pop_front();
          if (bus.o_coef_addr !== e.addr || bus.o_coef !== e.coef || rel != e.rel) begin
            bad++;
            $display("FAIL write_content: got addr=%0d coef=%h cycle=%0d, expected addr=%0d coef=%h cycle=%0d",
                     bus.o_coef_addr, bus.o_coef, rel, e.addr, e.coef, e.rel);
          end
        end
      end
      if (bus.o_done === 1'b1) begin
        done_cnt++;
        done_rel = rel;
      end
      if (chk_busy) begin
        exp_busy = (rel >= 1 && rel <= 49);
        total++;
        if (bus.o_busy !== exp_busy) begin
          bad++;
          $display("FAIL busy_window: cycle %0d got o_busy=%b, expected %b", rel, bus.o_busy, exp_busy);
        end
      end
    end
  end

  // Drive one full load. toggle=1 makes i_valid alternate 1/0; spur1/spur2
  // are relative cycles where i_start is pulsed; rst_at >= 0 asserts reset
  // at that cycle and abandons the stream.
  task automatic run_load(input bit toggle, input int spur1, input int spur2, input int rst_at);
    int idx;
    int r;
    bit v;
    sb.delete();
    writes_seen = 0;
    done_cnt    = 0;
    done_rel    = -1;
    last_wr_rel = -1;
    @(negedge clk);
    start_cyc   = cyc;
    bus.i_start = 1'b1;
    bus.i_valid = 1'b0;
    mon_en      = 1'b1;
    idx = 0;
    r   = 0;
    while ((idx < 2*SEGS || done_cnt == 0) && r < 400) begin
      @(negedge clk);
      r++;
      if (rst_at >= 0 && r == rst_at) begin
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_start = 1'b0;
        return;
      end
      bus.i_start = (r == spur1 || r == spur2);
      v = (idx < 2*SEGS) && (!toggle || r[0]);
      bus.i_valid = v;
      if (idx < 2*SEGS) bus.i_data = idx[0] ? b_vals[idx/2] : a_vals[idx/2];
      else              bus.i_data = '0;
      if (v && bus.o_ready === 1'b1) begin
        if (idx[0])
          sb.push_back('{addr: AW'(idx/2), coef: {a_vals[idx/2], b_vals[idx/2]}, rel: r + 1});
        idx++;
      end
    end
    total++;
    if (r >= 400) begin
      bad++;
      $display("FAIL load_timeout: got %0d words accepted and %0d done pulses after %0d cycles, expected %0d words and a done",
               idx, done_cnt, r, 2*SEGS);
    end
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_valid = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
  endtask

  // Common end-of-load checks.
  task automatic check_load(input string name, input int exp_last, input int exp_done);
    total++;
    if (writes_seen != SEGS || sb.size() != 0) begin
      bad++;
      $display("FAIL %s_write_count: got %0d writes (%0d still pending), expected %0d",
               name, writes_seen, sb.size(), SEGS);
    end
    total++;
    if (done_cnt != 1 || done_rel != exp_done) begin
      bad++;
      $display("FAIL %s_done: got %0d pulses, last at cycle %0d, expected 1 at cycle %0d",
               name, done_cnt, done_rel, exp_done);
    end
    total++;
    if (last_wr_rel != exp_last) begin
      bad++;
      $display("FAIL %s_last_write: got cycle %0d, expected %0d", name, last_wr_rel, exp_last);
    end
    total++;
    if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle_after: got busy=%b ready=%b, expected 0 0", name, bus.o_busy, bus.o_ready);
    end
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < SEGS; k++) begin
      a_vals[k] = N'(16'h0100 + k);
      b_vals[k] = N'(16'h0200 + k);
    end
  endtask

  task automatic test_reset();
    logic [2*N+AW+4:0] outs;
    rst_n       = 1'b0;
    bus.i_start = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {bus.o_ready, bus.o_coef, bus.o_coef_addr, bus.o_load_coef, bus.o_busy, bus.o_done};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_values: got outputs=%h, expected 0", outs);
    end
    rst_n       = 1'b1;
    bus.i_start = 1'b0;
    @(negedge clk);
    total++;
    if (bus.o_busy !== 1'b0 || bus.o_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_start_ignored: got busy=%b ready=%b, expected 0 0", bus.o_busy, bus.o_ready);
    end
  endtask

  task automatic test_full_load();
    fill_ramp();
    chk_busy = 1'b1;
    run_load(1'b0, -1, -1, -1);
    chk_busy = 1'b0;
    check_load("full", 48, 49);
    total++;
    if (bus.o_coef !== {16'h010F, 16'h020F} || bus.o_coef_addr !== AW'(15)) begin
      bad++;
      $display("FAIL full_hold: got coef=%h addr=%0d in IDLE, expected 010f020f 15",
               bus.o_coef, bus.o_coef_addr);
    end
  endtask

  task automatic test_back_pressure();
    fill_ramp();
    // Each segment takes a, gap, b, write: write k at 4+4k.
    run_load(1'b1, -1, -1, -1);
    check_load("backpressure", 64, 65);
  endtask

  task automatic test_spurious_start();
    fill_ramp();
    run_load(1'b0, 10, 49, -1);
    check_load("spurious", 48, 49);
  endtask

  task automatic test_reset_mid_load();
    logic [2*N+AW+4:0] outs;
    fill_ramp();
    run_load(1'b0, -1, -1, 20);
    @(negedge clk);
    outs = {bus.o_ready, bus.o_coef, bus.o_coef_addr, bus.o_load_coef, bus.o_busy, bus.o_done};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL midreset_values: got outputs=%h, expected 0", outs);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    total++;
    if (writes_seen != 6) begin
      bad++;
      $display("FAIL midreset_writes: got %0d writes, expected 6", writes_seen);
    end
    run_load(1'b0, -1, -1, -1);
    check_load("reload", 48, 49);
  endtask

  task automatic test_integration();
    logic [2*N-1:0] y;
    logic [N-1:0]   x;
    for (int k = 0; k < SEGS; k++) begin
      a_vals[k] = '0;
      b_vals[k] = '0;
      ram[k]    = {2*N{1'b1}};
    end
    a_vals[0] = 16'h0080;
    b_vals[0] = 16'h0040;
    run_load(1'b0, -1, -1, -1);
    check_load("integ", 48, 49);
    total++;
    if (ram[0] !== 32'h0080_0040 || ram[SEGS-1] !== '0) begin
      bad++;
      $display("FAIL integ_ram: got seg0=%h seg15=%h, expected 00800040 00000000", ram[0], ram[SEGS-1]);
    end
    x = 16'd5;
    y = x * ram[0][2*N-1:N] + {16'h0, ram[0][N-1:0]};
    total++;
    if (y !== 32'h0000_02C0) begin
      bad++;
      $display("FAIL integ_eval: got y=%h for x=5, expected 000002c0", y);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_back_pressure();
    test_spurious_start();
    test_reset_mid_load();
    test_integration();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
